// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encodings and widths for the PLL reset sequencer
package pll_seq_pkg;

    localparam int RETRY_W = 4;

    localparam logic [2:0] ST_PLL_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

endpackage

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - two-flop single-bit synchronizer, async reset to 0
module bit_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulsing, lock qualification, retry and fault supervision
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [2:0]         state
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRIES);

    logic               locked_s;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_reset_q, sys_reset_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    bit_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_LIM) begin
                        state_d = ST_PLL_RESET;
                        retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_PLL_RESET;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the transition edge.
        pll_rst_d   = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = fault_q || (state_d == ST_FAULT);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - randomized self-checking bench with a cycle-level reference model
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       refclk = 1'b0;
    logic       rst    = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst, sys_reset, ready, fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase number, cycles spent in phase, retries, lock sample history.
    int m_phase, m_t, m_retry;
    bit m_fault, m_s1, m_s2;

    always #10 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .state       (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_retry = 0; m_fault = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_go(input int p);
        m_phase = p;
        m_t     = 0;
        if (p == 4) m_fault = 1;
    endtask

    task automatic model_step(input bit lk);
        bit ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        case (m_phase)
            0: begin
                m_t++;
                if (m_t == RST_CYCLES) model_go(1);
            end
            1: begin
                m_t++;
                if (ls) model_go(2);
                else if (m_t == LOCK_TIMEOUT) begin
                    if (m_retry < MAX_RETRIES) begin
                        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                        model_go(0);
                    end else begin
                        model_go(4);
                    end
                end
            end
            2: begin
                if (!ls) model_go(1);
                else begin
                    m_t++;
                    if (m_t == STABLE_CYCLES) begin
                        model_go(3);
                        m_retry = 0;
                    end
                end
            end
            3: if (!ls) model_go(1);
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("pll_rst",     pll_rst,     (m_phase == 0 || m_phase == 4));
        check_eq("sys_reset",   sys_reset,   (m_phase != 3));
        check_eq("ready",       ready,       (m_phase == 3));
        check_eq("fault",       fault,       m_fault);
        check_eq("retry_count", retry_count, m_retry);
        check_eq("state",       state,       m_phase);
    endtask

    task automatic tick(input logic lk);
        @(negedge refclk);
        locked = lk;
        @(posedge refclk);
        cyc++;
        if (!rst) model_step(lk);
        #1;
        check_outputs();
    endtask

    // Asserts rst mid-cycle and checks the asynchronous reset values against constants.
    task automatic do_reset(input int hold);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_pll_rst",     pll_rst,     1);
        check_eq("rst_sys_reset",   sys_reset,   1);
        check_eq("rst_ready",       ready,       0);
        check_eq("rst_fault",       fault,       0);
        check_eq("rst_retry_count", retry_count, 0);
        check_eq("rst_state",       state,       0);
        repeat (hold) tick(1'($urandom_range(0, 1)));
        #2 rst = 1'b0;
    endtask

    task automatic wait_sig(input int sel, input logic val, input logic lk, input int limit, output int n);
        n = 0;
        while (n < limit && ((sel == 0) ? pll_rst : sys_reset) !== val) begin
            tick(lk);
            n++;
        end
    endtask

    initial begin
        int n;
        int falls;
        logic prev;
        model_reset();

        // Nominal lock: locked rises on the 10th cycle after release.
        do_reset(2);
        wait_sig(0, 1'b0, 1'b0, 50, n);
        check_eq("first_pulse_width", n, RST_CYCLES);
        repeat (9 - RST_CYCLES) tick(1'b0);
        wait_sig(1, 1'b0, 1'b1, 100, n);
        check_eq("lock_to_release", n, 3 + STABLE_CYCLES);
        check_eq("run_ready", ready, 1);
        check_eq("run_state", state, 3);

        // Lock loss in RUN, then relock before the timeout.
        repeat ($urandom_range(1, 10)) tick(1'b1);
        wait_sig(1, 1'b1, 1'b0, 20, n);
        check_eq("loss_latency", n, 3);
        check_eq("loss_state", state, 1);
        check_eq("loss_ready", ready, 0);
        repeat ($urandom_range(2, 12)) tick(1'b0);
        repeat (STABLE_CYCLES + 4) tick(1'b1);
        check_eq("relock_state", state, 3);

        // Retry then lock.
        do_reset($urandom_range(1, 3));
        repeat (RST_CYCLES + LOCK_TIMEOUT) tick(1'b0);
        check_eq("retry_state", state, 0);
        check_eq("retry_count_1", retry_count, 1);
        wait_sig(0, 1'b0, 1'b0, 50, n);
        check_eq("second_pulse_width", n, RST_CYCLES);
        repeat ($urandom_range(0, LOCK_TIMEOUT - 4)) tick(1'b0);
        wait_sig(1, 1'b0, 1'b1, 100, n);
        check_eq("retry_lock_release", n, 3 + STABLE_CYCLES);
        check_eq("retry_cleared", retry_count, 0);

        // Qualification abort: high 5, low 1, then high again.
        do_reset(2);
        repeat (RST_CYCLES) tick(1'b0);
        repeat (5) tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        check_eq("abort_state", state, 1);
        check_eq("abort_retry", retry_count, 0);
        // Remaining: one edge back into STABLE plus a full qualification window.
        wait_sig(1, 1'b0, 1'b1, 100, n);
        check_eq("abort_release", n, STABLE_CYCLES + 1);

        // Fault after MAX_RETRIES retries.
        do_reset(2);
        falls = 0;
        repeat ((MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT)) begin
            prev = pll_rst;
            tick(1'b0);
            if (prev && !pll_rst) falls++;
        end
        check_eq("fault_pulses", falls, MAX_RETRIES + 1);
        check_eq("fault_state", state, 4);
        check_eq("fault_flag", fault, 1);
        check_eq("fault_pll_rst", pll_rst, 1);
        check_eq("fault_sys_reset", sys_reset, 1);
        check_eq("fault_retry", retry_count, MAX_RETRIES);
        repeat (30) tick(1'($urandom_range(0, 1)));
        check_eq("fault_sticky", state, 4);

        // Reset mid-operation: second WAIT_LOCK, 15 cycles in, retry_count=1.
        do_reset(2);
        repeat (RST_CYCLES + LOCK_TIMEOUT + RST_CYCLES + 15) tick(1'b0);
        check_eq("mid_state", state, 1);
        check_eq("mid_retry", retry_count, 1);
        do_reset(1);
        wait_sig(0, 1'b0, 1'b0, 50, n);
        check_eq("mid_pulse_width", n, RST_CYCLES);

        // Random stress: locked held at random levels for random run lengths.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset($urandom_range(1, 3));
            for (int r = 0; r < 40; r++) begin
                logic lv;
                lv = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 30)) tick(lv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
